axi_mem_write_responder: RTL

Synthesizable AXI4 write-side responder that terminates one slave port of the crossbar. It accepts write bursts (AW/W), stores data into a private byte-addressed memory mapped at `BASE_ADDR`, and returns B responses. It is the RTL counterpart to the master agents' write traffic and lets the crossbar be checked against a real endpoint. A combinational debug read port exposes memory contents to the scoreboard.

---
 rtl/axi_mem_write_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/axi_mem_write_responder.sv
// axi_mem_write_responder: AXI4 write slave (AW queue, W sink, B response) storing into a byte memory at BASE_ADDR, with combinational debug read (dbg_addr -> dbg_rdata)
module axi_mem_write_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int ID_W = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int MEM_SIZE_LOG2 = 6,
  parameter int AW_FIFO_DEPTH = 4
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [ID_W-1:0]          awid,
  input  logic [ADDR_W-1:0]        awaddr,
  input  logic [7:0]               awlen,
  input  logic [2:0]               awsize,
  input  logic [1:0]               awburst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [ID_W-1:0]          bid,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [MEM_SIZE_LOG2-1:0] dbg_addr,
  output logic [DATA_W-1:0]        dbg_rdata
);
  localparam int LANES = DATA_W / 8;
  localparam int LW = $clog2(LANES);
  localparam int PW = $clog2(AW_FIFO_DEPTH);
  localparam int MW = MEM_SIZE_LOG2;
  localparam logic [ADDR_W-1:0] ONE = 1;
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } aw_t;
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t state;
  aw_t fifo [AW_FIFO_DEPTH];
  aw_t head;
  logic [PW:0] wr_ptr, rd_ptr;
  logic full, empty, push, pop;
  logic [ADDR_W-1:0] addr, bytes, mask, next_addr;
  logic [7:0] len, beat;
  logic [2:0] size;
  logic [1:0] burst, err, err_n;
  logic wrap_len_ok, last, bad, we;
  logic [7:0] mem [2**MW];
  logic [MW-1:0] woff, dbg_al;
  assign head = fifo[rd_ptr[PW-1:0]];
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {PW{1'b0}}};
  assign empty = wr_ptr == rd_ptr;
  assign awready = !full && !areset;
  assign push = awvalid && awready;
  assign pop = state == IDLE && !empty;
  assign last = beat == len;
  assign bad = wlast != last && err != 2'd3;
  assign we = state == DATA && wvalid && err == 2'd0;
  assign woff = addr[MW-1:0] & ~MW'(LANES - 1);
  assign dbg_al = dbg_addr & ~MW'(LANES - 1);
  always_comb begin
    wrap_len_ok = head.len == 8'd1 || head.len == 8'd3 || head.len == 8'd7 || head.len == 8'd15;
    err_n = head.addr[ADDR_W-1:MW] != BASE_ADDR[ADDR_W-1:MW] ? 2'd3 :
            (head.burst == 2'd3 || int'(head.size) > LW ||
             (head.burst == 2'd2 && (!wrap_len_ok || (head.addr & ((ONE << head.size) - ONE)) != '0))) ? 2'd2 : 2'd0;
    bytes = ONE << size;
    // wrap window is a power of two for every burst that actually writes
    mask = ((ADDR_W'(len) + ONE) << size) - ONE;
    next_addr = burst == 2'd0 ? addr :
                burst == 2'd2 ? (addr & ~mask) | ((addr + bytes) & mask) :
                (addr & ~(bytes - ONE)) + bytes;
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) wr_ptr <= '0;
    else if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
  always_ff @(posedge aclk)
    if (push) fifo[wr_ptr[PW-1:0]] <= '{awid, awaddr, awlen, awsize, awburst};
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      state <= IDLE;
      rd_ptr <= '0;
      wready <= 1'b0;
      bvalid <= 1'b0;
      bid <= '0;
      bresp <= '0;
      addr <= '0;
      len <= '0;
      size <= '0;
      burst <= '0;
      beat <= '0;
      err <= '0;
    end else
      case (state)
        IDLE: if (pop) begin
          rd_ptr <= rd_ptr + (PW+1)'(1);
          bid <= head.id;
          addr <= head.addr;
          len <= head.len;
          size <= head.size;
          burst <= head.burst;
          beat <= '0;
          err <= err_n;
          wready <= 1'b1;
          state <= DATA;
        end
        DATA: if (wvalid) begin
          if (bad) err <= 2'd2;
          if (last) begin
            wready <= 1'b0;
            bvalid <= 1'b1;
            bresp <= bad ? 2'd2 : err;
            state <= RESP;
          end else begin
            beat <= beat + 8'd1;
            addr <= next_addr;
          end
        end
        RESP: if (bready) begin
          bvalid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
  always_ff @(posedge aclk or posedge areset)
    if (areset) for (int i = 0; i < 2**MW; i++) mem[i] <= '0;
    else for (int j = 0; j < LANES; j++) if (we && wstrb[j]) mem[woff | MW'(j)] <= wdata[8*j+:8];
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign dbg_rdata[8*j+:8] = mem[dbg_al | MW'(j)];
  end
endmodule
